// File: rtl/reg_wr_port_arbiter_pkg.sv
// Shared definitions for the register-file write path.
// Holds the default widths, the r0 address and the arbiter state encoding.
package reg_wr_port_arbiter_pkg;

   localparam int DATA_WIDTH_DEF     = 32;
   localparam int REG_ADDR_WIDTH_DEF = 5;
   localparam int REG_ZERO           = 0;

   typedef enum logic {
      ARB   = 1'b0,
      FORCE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/reg_wr_fifo.sv
// Small synchronous FIFO that buffers multi-cycle results until they win the write port.
// The count is one bit wider than the pointers so that full and empty are distinct.
module reg_wr_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/reg_wr_port_arbiter.sv
// Shares the register-file write port between write-back (priority) and buffered
// multi-cycle results, forcing a one-cycle write-back stall when results starve.
module reg_wr_port_arbiter
   import reg_wr_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
   parameter int FIFO_DEPTH     = 2,
   parameter int MAX_WAIT       = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wb_reg_wr_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] wb_reg_wr_addr_in,
   input  logic [DATA_WIDTH-1:0]     wb_reg_wr_data_in,
   output logic                      wb_stall_out,
   input  logic                      mc_valid_in,
   input  logic [REG_ADDR_WIDTH-1:0] mc_addr_in,
   input  logic [DATA_WIDTH-1:0]     mc_data_in,
   output logic                      mc_ready_out,
   output logic                      reg_wr_en_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
   output logic [DATA_WIDTH-1:0]     reg_wr_data_out
);

   localparam int ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
   localparam int CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0]          LAST_WAIT = CNT_W'(MAX_WAIT - 1);
   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

   arb_state_t          state;
   arb_state_t          state_next;
   logic [CNT_W-1:0]    wait_cnt;
   logic [CNT_W-1:0]    wait_cnt_next;

   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic [ENTRY_W-1:0]  fifo_head;
   logic [REG_ADDR_WIDTH-1:0] head_addr;
   logic [DATA_WIDTH-1:0]     head_data;

   logic                      wb_req;
   logic                      fifo_req;
   logic                      grant;
   logic [REG_ADDR_WIDTH-1:0] grant_addr;
   logic [DATA_WIDTH-1:0]     grant_data;

   assign wb_req    = wb_reg_wr_en_in && (wb_reg_wr_addr_in != ZERO_ADDR);
   assign fifo_req  = !fifo_empty;
   assign head_addr = fifo_head[ENTRY_W-1:DATA_WIDTH];
   assign head_data = fifo_head[DATA_WIDTH-1:0];

   // Ready depends only on registered FIFO state; an r0 result completes the
   // handshake but is never stored.
   assign mc_ready_out = !fifo_full;
   assign fifo_push    = mc_valid_in && mc_ready_out && (mc_addr_in != ZERO_ADDR);
   assign wb_stall_out = (state == FORCE);

   reg_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({mc_addr_in, mc_data_in}),
      .head    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      grant         = 1'b0;
      grant_addr    = wb_reg_wr_addr_in;
      grant_data    = wb_reg_wr_data_in;
      fifo_pop      = 1'b0;
      case (state)
         ARB: begin
            if (wb_req) begin
               grant = 1'b1;
               if (fifo_req) begin
                  if (wait_cnt == LAST_WAIT) begin
                     state_next    = FORCE;
                     wait_cnt_next = '0;
                  end else begin
                     wait_cnt_next = wait_cnt + 1'b1;
                  end
               end else begin
                  wait_cnt_next = '0;
               end
            end else if (fifo_req) begin
               grant         = 1'b1;
               grant_addr    = head_addr;
               grant_data    = head_data;
               fifo_pop      = 1'b1;
               wait_cnt_next = '0;
            end else begin
               wait_cnt_next = '0;
            end
         end
         FORCE: begin
            // Write-back is stalled this cycle; its request is re-presented next cycle.
            grant         = fifo_req;
            grant_addr    = head_addr;
            grant_data    = head_data;
            fifo_pop      = fifo_req;
            wait_cnt_next = '0;
            state_next    = ARB;
         end
         default: begin
            state_next    = ARB;
            wait_cnt_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ARB;
         wait_cnt        <= '0;
         reg_wr_en_out   <= 1'b0;
         reg_wr_addr_out <= '0;
         reg_wr_data_out <= '0;
      end else begin
         state         <= state_next;
         wait_cnt      <= wait_cnt_next;
         reg_wr_en_out <= grant;
         if (grant) begin
            reg_wr_addr_out <= grant_addr;
            reg_wr_data_out <= grant_data;
         end
      end
   end

endmodule

// File: tb/tb_reg_wr_port_arbiter.sv
// Directed bench for reg_wr_port_arbiter: priority, buffering, starvation and r0 filtering.
module tb_reg_wr_port_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_stall;
   logic        mc_valid;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic        rf_en;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   int n_checks;
   int n_errors;

   reg_wr_port_arbiter #(
      .DATA_WIDTH     (32),
      .REG_ADDR_WIDTH (5),
      .FIFO_DEPTH     (2),
      .MAX_WAIT       (4)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .wb_reg_wr_en_in   (wb_en),
      .wb_reg_wr_addr_in (wb_addr),
      .wb_reg_wr_data_in (wb_data),
      .wb_stall_out      (wb_stall),
      .mc_valid_in       (mc_valid),
      .mc_addr_in        (mc_addr),
      .mc_data_in        (mc_data),
      .mc_ready_out      (mc_ready),
      .reg_wr_en_out     (rf_en),
      .reg_wr_addr_out   (rf_addr),
      .reg_wr_data_out   (rf_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      wb_en    = 1'b0;
      wb_addr  = '0;
      wb_data  = '0;
      mc_valid = 1'b0;
      mc_addr  = '0;
      mc_data  = '0;
      step();
      step();

      chk("rst_en",    rf_en,    1'b0);
      chk("rst_addr",  rf_addr,  5'd0);
      chk("rst_data",  rf_data,  32'd0);
      chk("rst_ready", mc_ready, 1'b1);
      chk("rst_stall", wb_stall, 1'b0);
      rst = 1'b0;
      step();

      // Write-back only
      wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
      step();
      wb_en = 1'b0;
      chk("wb_en",    rf_en,    1'b1);
      chk("wb_addr",  rf_addr,  5'd5);
      chk("wb_data",  rf_data,  32'hDEADBEEF);
      chk("wb_stall", wb_stall, 1'b0);
      step();
      chk("wb_one_cycle", rf_en, 1'b0);

      // Multi-cycle only: accepted N, popped N+1, visible N+2
      mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h12345678;
      chk("mc_ready", mc_ready, 1'b1);
      step();
      mc_valid = 1'b0;
      chk("mc_n1_en", rf_en, 1'b0);
      step();
      chk("mc_n2_en",   rf_en,   1'b1);
      chk("mc_n2_addr", rf_addr, 5'd7);
      chk("mc_n2_data", rf_data, 32'h12345678);
      step();
      chk("mc_n3_en", rf_en, 1'b0);

      // FIFO full while write-back is busy
      wb_en = 1'b1; wb_addr = 5'd10; wb_data = 32'hA0;
      mc_valid = 1'b1; mc_addr = 5'd1; mc_data = 32'h111;
      chk("full_f0_ready", mc_ready, 1'b1);
      step();
      wb_addr = 5'd11; wb_data = 32'hA1;
      mc_addr = 5'd2; mc_data = 32'h222;
      chk("full_f1_addr",  rf_addr,  5'd10);
      chk("full_f1_ready", mc_ready, 1'b1);
      step();
      wb_addr = 5'd12; wb_data = 32'hA2;
      mc_addr = 5'd4; mc_data = 32'h444;
      chk("full_f2_addr",  rf_addr,  5'd11);
      chk("full_f2_ready", mc_ready, 1'b0);
      step();
      wb_en = 1'b0;
      chk("full_f3_addr",  rf_addr,  5'd12);
      chk("full_f3_ready", mc_ready, 1'b0);
      step();
      chk("full_f4_en",    rf_en,    1'b1);
      chk("full_f4_addr",  rf_addr,  5'd1);
      chk("full_f4_data",  rf_data,  32'h111);
      chk("full_f4_ready", mc_ready, 1'b1);
      step();
      mc_valid = 1'b0;
      chk("full_f5_addr", rf_addr, 5'd2);
      chk("full_f5_data", rf_data, 32'h222);
      step();
      chk("full_f6_en",   rf_en,   1'b1);
      chk("full_f6_addr", rf_addr, 5'd4);
      chk("full_f6_data", rf_data, 32'h444);
      step();
      chk("full_f7_en", rf_en, 1'b0);

      // Starvation: one buffered entry, write-back requesting continuously
      mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h333;
      step();
      mc_valid = 1'b0;
      wb_en = 1'b1; wb_addr = 5'd20; wb_data = 32'h2000;
      step();
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("starve_wb%0d_en", i),    rf_en,    1'b1);
         chk($sformatf("starve_wb%0d_addr", i),  rf_addr,  5'd20);
         chk($sformatf("starve_wb%0d_stall", i), wb_stall, (i == 3) ? 1'b1 : 1'b0);
         step();
      end
      chk("starve_force_en",    rf_en,    1'b1);
      chk("starve_force_addr",  rf_addr,  5'd3);
      chk("starve_force_data",  rf_data,  32'h333);
      chk("starve_force_stall", wb_stall, 1'b0);
      step();
      wb_en = 1'b0;
      chk("starve_held_en",   rf_en,   1'b1);
      chk("starve_held_addr", rf_addr, 5'd20);
      chk("starve_held_data", rf_data, 32'h2000);
      step();
      chk("starve_idle_en", rf_en, 1'b0);

      // r0 filtering on both sources
      wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h5555;
      mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h6666;
      chk("r0_ready", mc_ready, 1'b1);
      step();
      wb_en = 1'b0; mc_valid = 1'b0;
      chk("r0_en1", rf_en, 1'b0);
      step();
      chk("r0_en2", rf_en, 1'b0);
      chk("r0_ready_after", mc_ready, 1'b1);

      // Reset mid-transfer with two buffered entries
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h9999;
      mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'h666;
      step();
      mc_addr = 5'd8; mc_data = 32'h888;
      step();
      mc_valid = 1'b0;
      chk("rmid_full", mc_ready, 1'b0);
      #2;
      rst   = 1'b1;
      wb_en = 1'b0;
      #1;
      chk("rmid_en",    rf_en,    1'b0);
      chk("rmid_ready", mc_ready, 1'b1);
      chk("rmid_stall", wb_stall, 1'b0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rmid_drop%0d_en", i), rf_en, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/reg_wr_port_arbiter.md
Name: reg_wr_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline write-back stage and a multi-cycle execution unit (mul/div).
- Pipeline write-back has priority.
- Multi-cycle results are buffered in a small FIFO.
- A starvation counter forces a slot for buffered results by stalling the write-back stage for one cycle.
- Sits between write_back and the register file; drives the register file's write enable, address and data.

Parameters:
- DATA_WIDTH, 32, register data width.
- REG_ADDR_WIDTH, 5, register address width.
- FIFO_DEPTH, 2, multi-cycle result buffer entries; power of two, >=2.
- MAX_WAIT, 4, consecutive cycles a non-empty FIFO loses arbitration before a slot is forced; >=1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wb_reg_wr_en_in  in  1  write request from write-back stage
- wb_reg_wr_addr_in  in  REG_ADDR_WIDTH  write-back destination register
- wb_reg_wr_data_in  in  DATA_WIDTH  write-back data
- wb_stall_out  out  1  write-back stage must hold its current request this cycle
- mc_valid_in  in  1  multi-cycle result valid
- mc_addr_in  in  REG_ADDR_WIDTH  multi-cycle destination register
- mc_data_in  in  DATA_WIDTH  multi-cycle result data
- mc_ready_out  out  1  FIFO can accept a result
- reg_wr_en_out  out  1  register-file write enable
- reg_wr_addr_out  out  REG_ADDR_WIDTH  register-file write address
- reg_wr_data_out  out  DATA_WIDTH  register-file write data

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on rst.
- Reset, any time including mid-operation:
  - reg_wr_en_out=0, addr=0, data=0.
  - FIFO flushed (count 0, pointers 0); pending results are discarded.
  - State ARB; wait counter 0.
  - mc_ready_out=1; wb_stall_out=0.
- Register-file outputs are registered: a grant in cycle N appears on reg_wr_* in cycle N+1. reg_wr_en_out is high for exactly one cycle per granted write.
- Effective requests:
  - wb_req = wb_reg_wr_en_in && wb_reg_wr_addr_in!=0.
  - fifo_req = FIFO non-empty.
  - Writes to r0 are never issued.
  - A mc result to r0 is accepted (handshake completes) and dropped, not pushed.
- mc handshake:
  - Push when mc_valid_in && mc_ready_out.
  - mc_ready_out = !full; it is registered-state derived, with no combinational path from the pop.
  - No push when full, even if a pop occurs that cycle.
  - Push and pop in the same cycle are allowed when not full.
  - A pushed entry is eligible for grant no earlier than the next cycle.
- State ARB:
  - wb_stall_out=0.
  - If wb_req: grant wb. If fifo_req is also set, wait_cnt increments.
  - Else if fifo_req: grant FIFO head, pop, wait_cnt=0.
  - Else: no grant (reg_wr_en_out=0 next cycle), wait_cnt=0.
  - If wait_cnt would reach MAX_WAIT: next state FORCE, wait_cnt=0.
- State FORCE, always exactly one cycle:
  - wb_stall_out=1, decoded from the state register.
  - Grant FIFO head and pop; any wb request is ignored, and write-back must present it again next cycle.
  - Next state ARB.
  - FIFO is guaranteed non-empty on entry (only the arbiter pops).
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits, so full and empty are distinguished.
- WAW between the pipeline and mc writes to the same register is excluded by the issue scoreboard. The arbiter preserves FIFO order only and does not compare addresses.

Decomposition:
- Shared package/include, alongside the other pipeline stages: DATA_WIDTH and REG_ADDR_WIDTH defaults, the REG_ZERO address constant, and the state encoding (ARB=1'b0, FORCE=1'b1).
- Sub-module reg_wr_fifo: synchronous FIFO (DEPTH, WIDTH=REG_ADDR_WIDTH+DATA_WIDTH) with push, pop, full, empty, and head data. It uses the same clk and async active-high rst.
- The arbitration FSM, wait counter and output registers stay in the top level.

Test Plan:
- Reset mid-transfer: 2 entries buffered, assert rst -> next cycle reg_wr_en_out=0, mc_ready_out=1, FIFO empty; buffered results are never written.
- wb only: wb_en=1, addr=5, data=0xDEADBEEF in cycle N -> cycle N+1 reg_wr_en_out=1, addr=5, data=0xDEADBEEF; wb_stall_out stays 0.
- mc only: mc_valid addr=7, data=0x12345678 while wb idle -> accepted in cycle N, popped in N+1, reg_wr_* shows it in N+2.
- FIFO full: 3 back-to-back mc results while wb is busy every cycle -> mc_ready_out=0 after the 2nd push; the 3rd is held until a pop frees an entry.
- Starvation: FIFO holds 1 entry (addr=3), wb requests continuously -> 4 wb grants, then FORCE with wb_stall_out=1 for one cycle, addr=3 written, and the held wb request is written the following cycle.
- r0 filtering: wb_en=1 addr=0, and mc_valid addr=0 -> no register-file write; mc handshake completes; FIFO count unchanged.
